// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: request payload and the arbiter lane bundle.
// Sized for the widest lane configuration; narrower instances use the low bits.
package vector_cache_pkg;

  localparam int unsigned VC_LANE_IDX_MAX_W = 8;
  localparam int unsigned VC_LANE_SRC_MAX_W = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  tag;
    logic        wr;
  } input_req_pld_t;

  typedef struct packed {
    input_req_pld_t                 pld;
    logic [VC_LANE_IDX_MAX_W-1:0]   mshr_idx;
    logic [VC_LANE_SRC_MAX_W-1:0]   src_id;
  } vc_arb_lane_t;

endpackage

// File: rtl/vc_n_to_m_req_arbiter_if.sv
// Signal bundle between requesters, MSHR allocator, arbiter and tag_ctrl.
// Handshake: a request transfers on a cycle where v_req_vld[i] & v_req_rdy[i]; the
// requester holds vld/pld until then. The output bundle transfers when |out_vld & out_rdy.
interface vc_n_to_m_req_arbiter_if
  import vector_cache_pkg::*;
#(
  parameter int unsigned REQ_NUM         = 8,
  parameter int unsigned GRANT_NUM       = 2,
  parameter int unsigned ENTRY_IDX_WIDTH = 4
);
  localparam int unsigned SW = $clog2(REQ_NUM);
  localparam int unsigned CW = $clog2(GRANT_NUM + 1);

  logic [REQ_NUM-1:0]                          v_req_vld;
  input_req_pld_t [REQ_NUM-1:0]                v_req_pld;
  logic [REQ_NUM-1:0]                          v_req_rdy;
  logic [CW-1:0]                               mshr_free_cnt;
  logic [GRANT_NUM-1:0][ENTRY_IDX_WIDTH-1:0]   mshr_alloc_idx;
  logic [CW-1:0]                               mshr_alloc_cnt;
  logic [GRANT_NUM-1:0]                        out_vld;
  input_req_pld_t [GRANT_NUM-1:0]              out_pld;
  logic [GRANT_NUM-1:0][ENTRY_IDX_WIDTH-1:0]   out_mshr_idx;
  logic [GRANT_NUM-1:0][SW-1:0]                out_src_id;
  logic                                        out_rdy;

  modport slave (
    input  v_req_vld, v_req_pld, mshr_free_cnt, mshr_alloc_idx, out_rdy,
    output v_req_rdy, mshr_alloc_cnt, out_vld, out_pld, out_mshr_idx, out_src_id
  );

  modport master (
    output v_req_vld, v_req_pld, mshr_free_cnt, mshr_alloc_idx, out_rdy,
    input  v_req_rdy, mshr_alloc_cnt, out_vld, out_pld, out_mshr_idx, out_src_id
  );

endinterface

// File: rtl/vc_rr_pick_m.sv
// Combinational rotating picker: scans mask from ptr upward (mod N) and
// returns the first up-to-limit set channels in scan order.
module vc_rr_pick_m #(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 2,
  parameter int unsigned PW = $clog2(N),
  parameter int unsigned CW = $clog2(M + 1)
) (
  input  logic [N-1:0]         mask,
  input  logic [PW-1:0]        ptr,
  input  logic [CW-1:0]        limit,
  output logic [M-1:0][PW-1:0] ids,
  output logic [CW-1:0]        cnt,
  output logic [N-1:0]         sel
);

  logic [PW:0]   sum;
  logic [PW-1:0] ch;
  int            taken;

  always_comb begin
    ids   = '0;
    sel   = '0;
    sum   = '0;
    ch    = '0;
    taken = 0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single conditional subtract implements mod N
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      ch = sum[PW-1:0];
      if (mask[ch] && (taken < int'(limit))) begin
        for (int g = 0; g < M; g++) begin
          if (g == taken) ids[g] = ch;
        end
        sel[ch] = 1'b1;
        taken   = taken + 1;
      end
    end
    cnt = CW'(taken);
  end

endmodule

// File: rtl/vc_n_to_m_req_arbiter.sv
// REQ_NUM-to-GRANT_NUM round-robin request arbiter with MSHR binding and a registered output bundle.
// Define VC_ARB_AGE_EN to add saturating per-channel age counters that promote starved channels.
module vc_n_to_m_req_arbiter
  import vector_cache_pkg::*;
#(
  parameter int unsigned REQ_NUM         = 8,
  parameter int unsigned GRANT_NUM       = 2,
  parameter int unsigned ENTRY_IDX_WIDTH = 4,
  parameter int unsigned AGE_WIDTH       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  vc_n_to_m_req_arbiter_if.slave              bus,
  output logic [$clog2(REQ_NUM)-1:0]          dbg_rr_ptr,
  output logic [REQ_NUM-1:0][AGE_WIDTH-1:0]   dbg_age
);

  localparam int unsigned SW = $clog2(REQ_NUM);
  localparam int unsigned CW = $clog2(GRANT_NUM + 1);

  logic                          load;
  logic [CW-1:0]                 limit;
  logic [SW-1:0]                 rr_ptr;
  logic [SW-1:0]                 last_id;
  logic [SW-1:0]                 next_rr;
  logic [GRANT_NUM-1:0][SW-1:0]  pick_ids;
  logic [CW-1:0]                 pick_cnt;
  logic [REQ_NUM-1:0]            pick_sel;

  // An empty bundle or a draining one frees the output register for a new grant.
  assign load = ~(|bus.out_vld) | bus.out_rdy;

  always_comb begin
    limit = '0;
    if (load && !rst) begin
      limit = (bus.mshr_free_cnt > CW'(GRANT_NUM)) ? CW'(GRANT_NUM) : bus.mshr_free_cnt;
    end
  end

`ifdef VC_ARB_AGE_EN
  logic [REQ_NUM-1:0][AGE_WIDTH-1:0] age;
  logic [REQ_NUM-1:0]                aged;
  logic [GRANT_NUM-1:0][SW-1:0]      ids_a, ids_b;
  logic [CW-1:0]                     cnt_a, cnt_b, limit_b;
  logic [REQ_NUM-1:0]                sel_a, sel_b;

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) aged[i] = &age[i];
  end

  vc_rr_pick_m #(.N(REQ_NUM), .M(GRANT_NUM), .PW(SW), .CW(CW)) u_pick_aged (
    .mask(bus.v_req_vld & aged), .ptr(rr_ptr), .limit(limit),
    .ids(ids_a), .cnt(cnt_a), .sel(sel_a)
  );

  assign limit_b = limit - cnt_a;

  vc_rr_pick_m #(.N(REQ_NUM), .M(GRANT_NUM), .PW(SW), .CW(CW)) u_pick_rest (
    .mask(bus.v_req_vld & ~aged), .ptr(rr_ptr), .limit(limit_b),
    .ids(ids_b), .cnt(cnt_b), .sel(sel_b)
  );

  // Starved channels take the low lanes; the round-robin picks fill the remainder.
  always_comb begin
    pick_ids = '0;
    for (int g = 0; g < GRANT_NUM; g++) begin
      if (CW'(g) < cnt_a) pick_ids[g] = ids_a[g];
      for (int j = 0; j < GRANT_NUM; j++) begin
        if ((CW'(g) >= cnt_a) && ((CW'(g) - cnt_a) == CW'(j)) && (CW'(j) < cnt_b)) begin
          pick_ids[g] = ids_b[j];
        end
      end
    end
  end

  assign pick_cnt = cnt_a + cnt_b;
  assign pick_sel = sel_a | sel_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (bus.v_req_vld[i] && pick_sel[i]) age[i] <= '0;
        else if (bus.v_req_vld[i] && !aged[i]) age[i] <= age[i] + AGE_WIDTH'(1);
      end
    end
  end

  assign dbg_age = age;
`else
  vc_rr_pick_m #(.N(REQ_NUM), .M(GRANT_NUM), .PW(SW), .CW(CW)) u_pick (
    .mask(bus.v_req_vld), .ptr(rr_ptr), .limit(limit),
    .ids(pick_ids), .cnt(pick_cnt), .sel(pick_sel)
  );

  assign dbg_age = '0;
`endif

  assign bus.v_req_rdy      = pick_sel;
  assign bus.mshr_alloc_cnt = pick_cnt;
  assign dbg_rr_ptr         = rr_ptr;

  always_comb begin
    last_id = '0;
    for (int g = 0; g < GRANT_NUM; g++) begin
      if (CW'(g + 1) == pick_cnt) last_id = pick_ids[g];
    end
    next_rr = (last_id == SW'(REQ_NUM - 1)) ? '0 : last_id + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_vld      <= '0;
      bus.out_pld      <= '0;
      bus.out_mshr_idx <= '0;
      bus.out_src_id   <= '0;
      rr_ptr           <= '0;
    end else begin
      if (load) begin
        for (int g = 0; g < GRANT_NUM; g++) begin
          if (CW'(g) < pick_cnt) begin
            bus.out_vld[g]      <= 1'b1;
            bus.out_pld[g]      <= bus.v_req_pld[pick_ids[g]];
            bus.out_mshr_idx[g] <= bus.mshr_alloc_idx[g];
            bus.out_src_id[g]   <= pick_ids[g];
          end else begin
            bus.out_vld[g]      <= 1'b0;
            bus.out_pld[g]      <= '0;
            bus.out_mshr_idx[g] <= '0;
            bus.out_src_id[g]   <= '0;
          end
        end
      end
      if (pick_cnt != '0) rr_ptr <= next_rr;
    end
  end

endmodule

// File: tb/tb_vc_n_to_m_req_arbiter.sv
// Bench for vc_n_to_m_req_arbiter (REQ_NUM=8, GRANT_NUM=2): directed cases plus
// randomized traffic compared every cycle against a queue-based selection model.
module tb_vc_n_to_m_req_arbiter;
  import vector_cache_pkg::*;

  localparam int REQ_NUM   = 8;
  localparam int GRANT_NUM = 2;
  localparam int EIW       = 4;
  localparam int AGE_W     = 2;
  localparam int SW        = 3;
  localparam int AGE_MAX   = (1 << AGE_W) - 1;
`ifdef VC_ARB_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_n_to_m_req_arbiter_if #(.REQ_NUM(REQ_NUM), .GRANT_NUM(GRANT_NUM), .ENTRY_IDX_WIDTH(EIW)) bus ();
  logic [SW-1:0]                  dbg_rr_ptr;
  logic [REQ_NUM-1:0][AGE_W-1:0]  dbg_age;

  vc_n_to_m_req_arbiter #(
    .REQ_NUM(REQ_NUM), .GRANT_NUM(GRANT_NUM), .ENTRY_IDX_WIDTH(EIW), .AGE_WIDTH(AGE_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_rr_ptr(dbg_rr_ptr), .dbg_age(dbg_age)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [GRANT_NUM-1:0] m_vld;
  input_req_pld_t       m_pld [GRANT_NUM];
  logic [EIW-1:0]       m_idx [GRANT_NUM];
  int                   m_src [GRANT_NUM];
  int                   m_rr;
  int                   m_age [REQ_NUM];
  logic [SW-1:0]        exp_q [$];
  logic [REQ_NUM-1:0]   gnt_seen = '0;
  bit                   chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        m_vld = '0;
        m_rr  = 0;
        for (int g = 0; g < GRANT_NUM; g++) begin
          m_pld[g] = '0; m_idx[g] = '0; m_src[g] = 0;
        end
        for (int i = 0; i < REQ_NUM; i++) m_age[i] = 0;
        check("rst_out_vld", bus.out_vld, '0);
        check("rst_out_pld", bus.out_pld, '0);
        check("rst_out_src", bus.out_src_id, '0);
        check("rst_out_idx", bus.out_mshr_idx, '0);
        check("rst_v_req_rdy", bus.v_req_rdy, '0);
        check("rst_alloc_cnt", bus.mshr_alloc_cnt, '0);
        gnt_seen = '0;
      end else begin
        bit                 load;
        int                 limit;
        logic [REQ_NUM-1:0] exp_rdy;
        for (int g = 0; g < GRANT_NUM; g++) begin
          check("out_vld", bus.out_vld[g], m_vld[g]);
          if (m_vld[g]) begin
            check("out_pld", bus.out_pld[g], m_pld[g]);
            check("out_mshr_idx", bus.out_mshr_idx[g], m_idx[g]);
            check("out_src_id", bus.out_src_id[g], m_src[g]);
          end
        end
        check("rr_ptr", dbg_rr_ptr, m_rr);
        for (int i = 0; i < REQ_NUM; i++) check("age", dbg_age[i], m_age[i]);

        // Selection: starved channels first (age mode only), each pass in rr order from m_rr.
        load  = (m_vld == '0) || bus.out_rdy;
        limit = load ? ((int'(bus.mshr_free_cnt) < GRANT_NUM) ? int'(bus.mshr_free_cnt) : GRANT_NUM) : 0;
        exp_q.delete();
        for (int pass = 0; pass < 2; pass++) begin
          for (int k = 0; k < REQ_NUM; k++) begin
            int ch;
            bit starved;
            ch      = (m_rr + k) % REQ_NUM;
            starved = AGE_ON && (m_age[ch] == AGE_MAX);
            if (bus.v_req_vld[ch] && (starved == (pass == 0)) && (exp_q.size() < limit))
              exp_q.push_back(SW'(ch));
          end
        end
        exp_rdy = '0;
        foreach (exp_q[j]) exp_rdy[exp_q[j]] = 1'b1;
        check("v_req_rdy", bus.v_req_rdy, exp_rdy);
        check("mshr_alloc_cnt", bus.mshr_alloc_cnt, exp_q.size());
        gnt_seen = bus.v_req_rdy;

        if (load) begin
          for (int g = 0; g < GRANT_NUM; g++) begin
            if (g < exp_q.size()) begin
              m_vld[g] = 1'b1;
              m_pld[g] = bus.v_req_pld[exp_q[g]];
              m_idx[g] = bus.mshr_alloc_idx[g];
              m_src[g] = int'(exp_q[g]);
            end else begin
              m_vld[g] = 1'b0;
            end
          end
        end
        if (exp_q.size() > 0) m_rr = (int'(exp_q[exp_q.size()-1]) + 1) % REQ_NUM;
        if (AGE_ON) begin
          for (int i = 0; i < REQ_NUM; i++) begin
            if (bus.v_req_vld[i]) begin
              if (exp_rdy[i]) m_age[i] = 0;
              else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic input_req_pld_t rand_pld();
    input_req_pld_t p;
    p.addr = $urandom;
    p.tag  = 8'($urandom_range(0, 255));
    p.wr   = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [REQ_NUM-1:0] vld, input int free, input int idx0, input bit ordy);
    bus.v_req_vld         = vld;
    bus.mshr_free_cnt     = 2'(free);
    bus.mshr_alloc_idx[0] = EIW'(idx0);
    bus.mshr_alloc_idx[1] = EIW'($urandom_range(0, 15));
    bus.out_rdy           = ordy;
    for (int i = 0; i < REQ_NUM; i++) bus.v_req_pld[i] = rand_pld();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.v_req_vld      = '0;
    bus.v_req_pld      = '0;
    bus.mshr_free_cnt  = '0;
    bus.mshr_alloc_idx = '0;
    bus.out_rdy        = 1'b0;
    chk_en             = 1'b1;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rr_ptr", dbg_rr_ptr, 0);
    check("reset_out_vld", bus.out_vld, 0);

    // 1: all valid from rr_ptr=0
    drive(8'hFF, 2, 3, 1'b1);
    #1 check("t1_rdy", bus.v_req_rdy, 8'h03);
    check("t1_alloc_cnt", bus.mshr_alloc_cnt, 2);
    tick();
    check("t1_out_vld", bus.out_vld, 2'b11);
    check("t1_lane0", bus.out_src_id[0], 0);
    check("t1_lane1", bus.out_src_id[1], 1);
    check("t1_rr", dbg_rr_ptr, 2);

    // 2: walk rr_ptr to 7, then wrap
    drive(8'h60, 2, 1, 1'b1);
    #1 check("t2a_rdy", bus.v_req_rdy, 8'h60);
    tick();
    check("t2a_rr", dbg_rr_ptr, 7);
    drive(8'h81, 2, 2, 1'b1);
    #1 check("t2_rdy", bus.v_req_rdy, 8'h81);
    tick();
    check("t2_lane0", bus.out_src_id[0], 7);
    check("t2_lane1", bus.out_src_id[1], 0);
    check("t2_rr", dbg_rr_ptr, 1);

    // 3: single free entry
    drive(8'h0C, 1, 5, 1'b1);
    #1 check("t3_rdy", bus.v_req_rdy, 8'h04);
    check("t3_alloc_cnt", bus.mshr_alloc_cnt, 1);
    tick();
    check("t3_out_vld", bus.out_vld, 2'b01);
    check("t3_mshr_idx", bus.out_mshr_idx[0], 5);
    check("t3_src", bus.out_src_id[0], 2);
    check("t3_rr", dbg_rr_ptr, 3);

    // 4: stall a full bundle, then back-to-back reload
    drive(8'hFF, 2, 6, 1'b1);
    tick();
    bus.out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check("t4_stall_rdy", bus.v_req_rdy, 8'h00);
      check("t4_stall_cnt", bus.mshr_alloc_cnt, 0);
      tick();
      check("t4_hold_vld", bus.out_vld, 2'b11);
      check("t4_hold_src0", bus.out_src_id[0], 3);
      check("t4_hold_src1", bus.out_src_id[1], 4);
    end
    bus.out_rdy = 1'b1;
    #1 check("t4_reload_rdy", bus.v_req_rdy, 8'h60);
    tick();
    check("t4_reload_src0", bus.out_src_id[0], 5);
    check("t4_reload_src1", bus.out_src_id[1], 6);
    check("t4_rr", dbg_rr_ptr, 7);

    // 5: asynchronous reset mid-cycle with a full bundle held
    #2 rst = 1'b1;
    #1 check("t5_async_out_vld", bus.out_vld, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    #1 check("t5_rr_after", dbg_rr_ptr, 0);

    // 6: ch6 loses three rounds at free=1, then starvation promotion (age mode)
    drive(8'h41, 1, 0, 1'b1); tick();
    drive(8'h42, 1, 0, 1'b1); tick();
    drive(8'h44, 1, 0, 1'b1); tick();
    drive(8'h48, 1, 0, 1'b1);
    #1 check("t6_rdy", bus.v_req_rdy, AGE_ON ? 8'h40 : 8'h08);
    tick();
    check("t6_lane0", bus.out_src_id[0], AGE_ON ? 6 : 3);

    // Randomized traffic: requesters hold vld/pld until granted.
    bus.v_req_vld = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc == 1500) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      for (int i = 0; i < REQ_NUM; i++) begin
        if (bus.v_req_vld[i]) begin
          if (gnt_seen[i]) begin
            if ($urandom_range(0, 1) == 0) bus.v_req_vld[i] = 1'b0;
            else bus.v_req_pld[i] = rand_pld();
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.v_req_vld[i] = 1'b1;
          bus.v_req_pld[i] = rand_pld();
        end
      end
      bus.mshr_free_cnt     = 2'($urandom_range(0, 2));
      bus.mshr_alloc_idx[0] = EIW'($urandom_range(0, 15));
      bus.mshr_alloc_idx[1] = EIW'($urandom_range(0, 15));
      bus.out_rdy           = ($urandom_range(0, 3) != 0);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
